// File: rtl/flush_ctrl_if.sv
// Control-flow redirect bundle between pipeline resolve logic, fetch and flush_ctrl.
// The master drives resolve events and fetch acceptance; the slave returns flushes and the redirect.
interface flush_ctrl_if #(
    parameter int NSTAGE = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              br_taken;
    logic              jump;
    logic [ADDR_W-1:0] br_target;
    logic              exc_req;
    logic [ADDR_W-1:0] exc_vector;
    logic              redir_ready;
    logic [NSTAGE-1:0] flush;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic              busy;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output br_taken, jump, br_target, exc_req, exc_vector, redir_ready,
        input  flush, redir_valid, redir_pc, busy, flush_cnt
    );

    modport slave (
        input  br_taken, jump, br_target, exc_req, exc_vector, redir_ready,
        output flush, redir_valid, redir_pc, busy, flush_cnt
    );
endinterface

// File: rtl/flush_ctrl.sv
// Pipeline flush and fetch-redirect controller: combinational flush vector, registered redirect.
// Latency: flush in the event cycle, redir_valid one cycle after the event.
// Backpressure: redirect held stable until redir_ready; only an exception may overwrite it.
module flush_ctrl #(
    parameter int NSTAGE    = 4,
    parameter int BR_STAGE  = 2,
    parameter int EXC_STAGE = 3,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    flush_ctrl_if.slave bus
);
    localparam logic [NSTAGE-1:0] ALL_ONES = {NSTAGE{1'b1}};
    localparam logic [NSTAGE-1:0] BR_MASK  = ALL_ONES >> (NSTAGE - 1 - BR_STAGE);
    localparam logic [NSTAGE-1:0] EXC_MASK = ALL_ONES >> (NSTAGE - 1 - EXC_STAGE);
    localparam logic [NSTAGE-1:0] IF_MASK  = NSTAGE'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic              redir_valid_q;
    logic [ADDR_W-1:0] redir_pc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              br_ev;
    logic [NSTAGE-1:0] flush_d;
    logic [CNT_W-1:0]  cnt_d;

    assign br_ev = bus.br_taken | bus.jump;
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Exceptions flush deeper than branches and are honoured in either state.
    always_comb begin
        flush_d = '0;
        if (!reset) begin
            if (bus.exc_req) begin
                flush_d = EXC_MASK;
            end else if (state_q == IDLE && br_ev) begin
                flush_d = BR_MASK;
            end else if (state_q == WAIT) begin
                flush_d = IF_MASK;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.exc_req) begin
                        state_q       <= WAIT;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= bus.exc_vector;
                        cnt_q         <= cnt_d;
                    end else if (br_ev) begin
                        state_q       <= WAIT;
                        redir_valid_q <= 1'b1;
                        redir_pc_q    <= bus.br_target;
                        cnt_q         <= cnt_d;
                    end
                end
                WAIT: begin
                    // A late exception supersedes the pending redirect and eats the handshake.
                    if (bus.exc_req) begin
                        redir_pc_q <= bus.exc_vector;
                        cnt_q      <= cnt_d;
                    end else if (bus.redir_ready) begin
                        state_q       <= IDLE;
                        redir_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    redir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush       = flush_d;
    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.busy        = (state_q == WAIT);
    assign bus.flush_cnt   = cnt_q;
endmodule

// File: tb/tb_flush_ctrl.sv
// Randomized plus directed bench for flush_ctrl against a transaction-level redirect model.
module tb_flush_ctrl;
    localparam int NSTAGE = 4;
    localparam int BRS    = 2;
    localparam int EXCS   = 3;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference: is a redirect outstanding, where to, and how many events accepted.
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_cnt;

    flush_ctrl_if #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    flush_ctrl #(
        .NSTAGE(NSTAGE), .BR_STAGE(BRS), .EXC_STAGE(EXCS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int low_mask(input int hi);
        return (1 << (hi + 1)) - 1;
    endfunction

    // Drive one cycle, check at the falling edge, advance the model at the rising edge.
    task automatic step(input bit r, input bit bt, input bit jp, input logic [31:0] tgt,
                        input bit ex, input logic [31:0] vec, input bit rdy);
        int exp_flush;
        reset           = r;
        bus.br_taken    = bt;
        bus.jump        = jp;
        bus.br_target   = tgt;
        bus.exc_req     = ex;
        bus.exc_vector  = vec;
        bus.redir_ready = rdy;
        if (r)                     exp_flush = 0;
        else if (ex)               exp_flush = low_mask(EXCS);
        else if (!m_pend && (bt || jp)) exp_flush = low_mask(BRS);
        else if (m_pend)           exp_flush = 1;
        else                       exp_flush = 0;
        @(negedge clk);
        check("flush", 64'(bus.flush), 64'(exp_flush));
        check("redir_valid", 64'(bus.redir_valid), 64'(m_pend));
        check("redir_pc", 64'(bus.redir_pc), 64'(m_pc));
        check("busy", 64'(bus.busy), 64'(m_pend));
        check("flush_cnt", 64'(bus.flush_cnt), 64'(m_cnt));
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_pc = '0; m_cnt = 0;
        end else if (ex) begin
            m_pend = 1; m_pc = vec; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (!m_pend && (bt || jp)) begin
            m_pend = 1; m_pc = tgt; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (m_pend && rdy) begin
            m_pend = 0;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 32'h0, 0, 32'h0, rdy);
    endtask

    initial begin
        int sat_exp [5];
        checks = 0; errors = 0;
        m_pend = 0; m_pc = '0; m_cnt = 0;
        sat_exp = '{1, 2, 3, 3, 3};
        reset = 1'b1;
        bus.br_taken = 0; bus.jump = 0; bus.br_target = '0;
        bus.exc_req = 0; bus.exc_vector = '0; bus.redir_ready = 0;
        @(posedge clk); #1;

        // Reset state, with noisy inputs held during reset.
        step(1, 1, 1, 32'hdead_beef, 1, 32'hcafe_f00d, 1);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);

        // Branch then backpressure then acknowledge.
        step(0, 1, 0, 32'h0040_0020, 0, 32'h0, 0);
        check("br_pc", 64'(bus.redir_pc), 64'h0040_0020);
        check("br_cnt", 64'(bus.flush_cnt), 64'd1);
        idle(0); idle(0); idle(0);
        step(0, 1, 1, 32'h1234_0000, 0, 32'h0, 0);
        check("br_in_wait_pc", 64'(bus.redir_pc), 64'h0040_0020);
        idle(1);
        check("ack_valid", 64'(bus.redir_valid), 64'd0);
        idle(0);

        // Jump and exception together.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h0000_0444, 1, 32'h8000_0180, 0);
        check("prio_pc", 64'(bus.redir_pc), 64'h8000_0180);
        check("prio_cnt", 64'(bus.flush_cnt), 64'd1);
        idle(1);

        // Exception in WAIT colliding with ready.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0000_0100, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1, 32'h8000_0180, 1);
        check("exc_wait_busy", 64'(bus.busy), 64'd1);
        check("exc_wait_pc", 64'(bus.redir_pc), 64'h8000_0180);
        check("exc_wait_cnt", 64'(bus.flush_cnt), 64'd2);
        idle(1);
        check("exc_wait_ack", 64'(bus.busy), 64'd0);

        // Counter saturation.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 32'h0000_1000 + 32'(k), 0, 32'h0, 0);
            check("sat_cnt", 64'(bus.flush_cnt), 64'(sat_exp[k]));
            idle(1);
        end

        // Reset mid-WAIT.
        step(0, 0, 1, 32'h0000_2000, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 1, 32'h8000_0180, 1);
        check("rst_wait_valid", 64'(bus.redir_valid), 64'd0);
        check("rst_wait_pc", 64'(bus.redir_pc), 64'd0);
        idle(0);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 11) == 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flush_ctrl.md
FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 Parameter NSTAGE, default 4: number of pipeline registers; bit i of flush maps to register i (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB).
REQ-002 Parameter BR_STAGE, default 2: highest register index cleared on branch/jump; legal range 0..NSTAGE-1.
REQ-003 Parameter EXC_STAGE, default 3: highest register index cleared on exception; legal range BR_STAGE..NSTAGE-1.
REQ-004 Parameter ADDR_W, default 32: redirect PC width.
REQ-005 Parameter CNT_W, default 16: flush event counter width.
REQ-006 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port br_taken, input, 1: resolved taken branch this cycle.
REQ-009 Port jump, input, 1: jump resolved this cycle.
REQ-010 Port br_target, input, ADDR_W: target for br_taken/jump.
REQ-011 Port exc_req, input, 1: exception raised this cycle.
REQ-012 Port exc_vector, input, ADDR_W: handler address for exc_req.
REQ-013 Port redir_ready, input, 1: fetch accepts redirect.
REQ-014 Port flush, output, NSTAGE: per-register clear vector.
REQ-015 Port redir_valid, output, 1: registered redirect request to fetch.
REQ-016 Port redir_pc, output, ADDR_W: registered redirect address.
REQ-017 Port busy, output, 1: high while FSM is in WAIT.
REQ-018 Port flush_cnt, output, CNT_W: accepted flush events, saturating.

Function
REQ-019 FSM SHALL have two states: IDLE, WAIT.
REQ-020 Event in IDLE SHALL be: exc_req, else br_taken or jump; exc_req takes priority when both are high in the same cycle.
REQ-021 flush SHALL be combinational in the event cycle: exception sets bits 0..EXC_STAGE; branch/jump sets bits 0..BR_STAGE; all other bits 0.
REQ-022 On an IDLE event, the next edge SHALL load redir_pc (exc_vector or br_target), set redir_valid=1, and enter WAIT; latency from event to redir_valid is 1 cycle.
REQ-023 In WAIT, flush[0] SHALL be held 1 every cycle to discard wrong-path fetches; other bits are 0 unless REQ-025 applies.
REQ-024 In WAIT, br_taken/jump SHALL be ignored: no flush bits, no counter increment, redir_pc unchanged.
REQ-025 In WAIT, exc_req SHALL set flush bits 0..EXC_STAGE that cycle, overwrite redir_pc with exc_vector at the next edge, keep redir_valid=1, remain in WAIT, and increment flush_cnt.
REQ-026 Handshake: redir_valid && redir_ready at an edge with no exc_req SHALL clear redir_valid and return to IDLE; redir_pc holds its last value.
REQ-027 redir_ready && exc_req in the same WAIT cycle: exception wins (REQ-025); the handshake is not consumed.
REQ-028 redir_valid and redir_pc SHALL not change while redir_valid=1 and redir_ready=0, except per REQ-025.
REQ-029 flush_cnt SHALL increment by 1 per accepted event and saturate at 2^CNT_W-1 with no wrap.
REQ-030 busy SHALL equal (state==WAIT), which also equals redir_valid.
REQ-031 Inputs arriving while reset=1 SHALL be ignored.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE, redir_valid=0, redir_pc=0, flush_cnt=0, busy=0.
REQ-033 While reset=1, flush SHALL be all zeros.
REQ-034 Reset asserted during WAIT SHALL abandon the pending redirect; no handshake completes.

Verification
REQ-035 Branch: idle, br_taken=1, br_target=0x00400020 for 1 cycle -> flush=4'b0111 that cycle; next cycle redir_valid=1, redir_pc=0x00400020, flush=4'b0001, busy=1; flush_cnt=1.
REQ-036 Backpressure: hold redir_ready=0 for 3 cycles, then 1 -> redir_valid/pc stable for 3 cycles, flush[0]=1 throughout; IDLE and redir_valid=0 after the ready edge.
REQ-037 Priority: jump=1 and exc_req=1 together, exc_vector=0x80000180 -> flush=4'b1111, redir_pc=0x80000180, flush_cnt=1.
REQ-038 Exception in WAIT: pending branch redirect 0x100, exc_req with 0x80000180 in the same cycle as redir_ready=1 -> still WAIT, redir_pc=0x80000180, flush_cnt=2; second ready returns to IDLE.
REQ-039 Saturation: CNT_W=2, 5 separate branch events each acknowledged -> flush_cnt sequence 1,2,3,3,3.
REQ-040 Reset mid-WAIT: reset=1 while redir_valid=1 -> next cycle redir_valid=0, redir_pc=0, flush_cnt=0, flush=0.
